// File: rtl/mme_result_writer.sv
// Drains the 16-element C result stream row by row. Each 4-word row is buffered, then written
// as one 4-beat INCR AXI burst. Write-response errors are collected into a sticky flag.
module mme_result_writer #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] c_addr_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  input  logic              res_valid_i,
  input  logic [DATA_W-1:0] res_data_i,
  output logic              res_ready_o,
  output logic [ADDR_W-1:0] awaddr_o,
  output logic [3:0]        awlen_o,
  output logic [2:0]        awsize_o,
  output logic [1:0]        awburst_o,
  output logic              awvalid_o,
  input  logic              awready_i,
  output logic [DATA_W-1:0] wdata_o,
  output logic [3:0]        wstrb_o,
  output logic              wlast_o,
  output logic              wvalid_o,
  input  logic              wready_i,
  input  logic [1:0]        bresp_i,
  input  logic              bvalid_i,
  output logic              bready_o
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StFill = 3'd1;
  localparam logic [2:0] StAw   = 3'd2;
  localparam logic [2:0] StW    = 3'd3;
  localparam logic [2:0] StB    = 3'd4;
  localparam logic [2:0] StDone = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [1:0]        row_q, row_d;
  logic [1:0]        beat_q, beat_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] buf_q [4];
  logic [DATA_W-1:0] buf_d [4];
  logic              err_q, err_d;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    beat_d  = beat_q;
    base_d  = base_q;
    buf_d   = buf_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          // Bursts are row-aligned to 16 bytes, so they never straddle a 4 KB page.
          base_d  = c_addr_i & ~ADDR_W'(4'hF);
          row_d   = 2'd0;
          beat_d  = 2'd0;
          err_d   = 1'b0;
          state_d = StFill;
        end
      end
      StFill: begin
        if (res_valid_i) begin
          buf_d[beat_q] = res_data_i;
          beat_d        = beat_q + 2'd1;
          if (beat_q == 2'd3) state_d = StAw;
        end
      end
      StAw: begin
        if (awready_i) state_d = StW;
      end
      StW: begin
        if (wready_i) begin
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) state_d = StB;
        end
      end
      StB: begin
        if (bvalid_i) begin
          if (bresp_i != 2'b00) err_d = 1'b1;
          if (row_q == 2'd3) begin
            state_d = StDone;
          end else begin
            row_d   = row_q + 2'd1;
            state_d = StFill;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      row_q   <= 2'd0;
      beat_q  <= 2'd0;
      base_q  <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < 4; i++) buf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
      err_q   <= err_d;
      buf_q   <= buf_d;
    end
  end

  // All outputs are Moore: stalls cannot disturb them.
  assign busy_o      = (state_q != StIdle);
  assign done_o      = (state_q == StDone);
  assign err_o       = err_q;
  assign res_ready_o = (state_q == StFill);
  assign awvalid_o   = (state_q == StAw);
  assign awaddr_o    = base_q + ADDR_W'({row_q, 4'b0000});
  assign awlen_o     = 4'd3;
  assign awsize_o    = 3'b010;
  assign awburst_o   = 2'b01;
  assign wvalid_o    = (state_q == StW);
  assign wdata_o     = buf_q[beat_q];
  assign wstrb_o     = 4'hF;
  assign wlast_o     = (state_q == StW) && (beat_q == 2'd3);
  assign bready_o    = (state_q == StB);

endmodule

// File: tb/tb_mme_result_writer.sv
// Bench for mme_result_writer: table of transfer scenarios, queue scoreboard for the AW and W
// channels, and a randomly stalling AXI slave.
module tb_mme_result_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] c_addr_i = '0;
  logic        busy_o, done_o, err_o;
  logic        res_valid_i = 1'b0;
  logic [31:0] res_data_i = '0;
  logic        res_ready_o;
  logic [31:0] awaddr_o;
  logic [3:0]  awlen_o;
  logic [2:0]  awsize_o;
  logic [1:0]  awburst_o;
  logic        awvalid_o;
  logic        awready_i = 1'b0;
  logic [31:0] wdata_o;
  logic [3:0]  wstrb_o;
  logic        wlast_o, wvalid_o;
  logic        wready_i = 1'b0;
  logic [1:0]  bresp_i = 2'b00;
  logic        bvalid_i = 1'b0;
  logic        bready_o;

  mme_result_writer #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .c_addr_i(c_addr_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .res_valid_i(res_valid_i), .res_data_i(res_data_i), .res_ready_o(res_ready_o),
    .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awsize_o(awsize_o), .awburst_o(awburst_o),
    .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o), .wvalid_o(wvalid_o),
    .wready_i(wready_i),
    .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] base;
    logic [31:0] data0;
    int          err_row;  // 4 = no error response
    bit          stall;
    bit          poke;
    bit          abort;
    bit          exp_err;
  } op_t;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_aw [$];
  logic [32:0] exp_w  [$];
  int aw_cnt = 0, w_cnt = 0, done_cnt = 0, b_cnt = 0, b_pend = 0, err_b = -1;
  bit stall_en = 1'b0, b_hs = 1'b0;
  bit aw_open = 1'b0, prev_aw_stall = 1'b0, prev_w_stall = 1'b0;
  logic [31:0] prev_awaddr, prev_wdata;
  logic        prev_wlast;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp_v);
    end
  endtask

  // AXI slave: inputs change only on the falling edge.
  always @(negedge clk) begin
    if (stall_en) begin
      awready_i = ($urandom_range(0, 2) == 0);
      wready_i  = ($urandom_range(0, 2) == 0);
    end else begin
      awready_i = 1'b1;
      wready_i  = 1'b1;
    end
    if (rst) begin
      bvalid_i = 1'b0;
      b_pend   = 0;
      b_hs     = 1'b0;
    end else begin
      if (b_hs) begin
        bvalid_i = 1'b0;
        b_hs     = 1'b0;
      end
      if (!bvalid_i && b_pend > 0 && (!stall_en || $urandom_range(0, 2) == 0)) begin
        bvalid_i = 1'b1;
        bresp_i  = (b_cnt == err_b) ? 2'b10 : 2'b00;
      end
      if (bvalid_i && bready_o) begin
        b_hs = 1'b1;
        b_pend--;
        b_cnt++;
      end
      if (wvalid_o && wready_i && wlast_o) b_pend++;
    end
  end

  // Monitor: sees the values that the next rising edge will sample.
  always begin
    logic [31:0] ea;
    logic [32:0] ew;
    @(negedge clk);
    #1;
    if (rst) begin
      prev_aw_stall = 1'b0;
      prev_w_stall  = 1'b0;
      aw_open       = 1'b0;
    end else begin
      if (prev_aw_stall) begin
        check("aw_hold_valid", awvalid_o, 1);
        check("aw_hold_addr", awaddr_o, prev_awaddr);
      end
      if (prev_w_stall) begin
        check("w_hold_valid", wvalid_o, 1);
        check("w_hold_data", wdata_o, prev_wdata);
        check("w_hold_last", wlast_o, prev_wlast);
      end
      if (res_ready_o) check("ready_exclusive", {awvalid_o, wvalid_o, bready_o}, 0);
      if (wvalid_o) check("w_after_aw", aw_open, 1);
      if (awvalid_o && awready_i) begin
        if (exp_aw.size() == 0) begin
          check("aw_unexpected", awaddr_o, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          ea = exp_aw.pop_front();
          check("awaddr", awaddr_o, ea);
          check("aw_attr", {awlen_o, awsize_o, awburst_o}, {4'd3, 3'b010, 2'b01});
        end
        aw_open = 1'b1;
        aw_cnt++;
      end
      if (wvalid_o && wready_i) begin
        if (exp_w.size() == 0) begin
          check("w_unexpected", wdata_o, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          ew = exp_w.pop_front();
          check("wdata", wdata_o, ew[31:0]);
          check("wlast", wlast_o, ew[32]);
          check("wstrb", wstrb_o, 4'hF);
        end
        w_cnt++;
        if (wlast_o) aw_open = 1'b0;
      end
      if (done_o) done_cnt++;
      prev_aw_stall = awvalid_o && !awready_i;
      prev_w_stall  = wvalid_o && !wready_i;
      prev_awaddr   = awaddr_o;
      prev_wdata    = wdata_o;
      prev_wlast    = wlast_o;
    end
  end

  task automatic run_op(input op_t op);
    logic [31:0] data [16];
    logic [31:0] abase;
    int idx, cyc, aw0, w0, d0;
    bit finished, aborted;
    abase = op.base & 32'hFFFF_FFF0;
    for (int i = 0; i < 16; i++) begin
      data[i] = op.data0 + 32'(i);
      exp_w.push_back({(i % 4 == 3), data[i]});
    end
    for (int r = 0; r < 4; r++) exp_aw.push_back(abase + 32'(r * 16));
    stall_en = op.stall;
    err_b    = b_cnt + op.err_row;
    aw0 = aw_cnt; w0 = w_cnt; d0 = done_cnt;
    idx = 0; cyc = 0; finished = 1'b0; aborted = 1'b0;
    @(negedge clk);
    start_i  = 1'b1;
    c_addr_i = op.base;
    while (!finished && !aborted && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start_i  = op.poke && (cyc == 20);
      c_addr_i = start_i ? 32'hDEAD_0000 : op.base;
      if (idx < 16 && (!op.stall || $urandom_range(0, 3) != 0)) begin
        res_valid_i = 1'b1;
        res_data_i  = data[idx];
        if (res_ready_o) idx++;
      end else begin
        res_valid_i = 1'b0;
      end
      #2;
      if (cyc == 1) begin
        check("busy_after_start", busy_o, 1);
        check("err_cleared_by_start", err_o, 0);
      end
      if (op.abort && wvalid_o && (w_cnt - (wready_i ? 1 : 0)) == w0 + 10) begin
        rst     = 1'b1;
        aborted = 1'b1;
      end else if (done_o) begin
        check("err_at_done", err_o, op.exp_err);
        finished = 1'b1;
        if (op.poke) begin
          start_i  = 1'b1;
          c_addr_i = 32'h0000_5550;
        end
      end
    end
    res_valid_i = 1'b0;
    if (op.abort) begin
      check("abort_reached", aborted, 1);
      @(negedge clk);
      #2;
      check("abort_busy", busy_o, 0);
      check("abort_valids", {done_o, res_ready_o, awvalid_o, wvalid_o, wlast_o, bready_o}, 0);
      check("abort_addr_data", {awaddr_o, wdata_o}, 0);
      check("abort_err", err_o, 0);
      rst = 1'b0;
      exp_aw.delete();
      exp_w.delete();
    end else begin
      check("done_seen", finished, 1);
      check("aw_bursts", aw_cnt - aw0, 4);
      check("w_beats", w_cnt - w0, 16);
      check("done_pulses", done_cnt - d0, 1);
      check("aw_queue_empty", exp_aw.size(), 0);
      check("w_queue_empty", exp_w.size(), 0);
      if (op.poke) begin
        @(negedge clk);
        start_i = 1'b0;
        #2;
        check("start_in_done_ignored", busy_o, 0);
      end
    end
  endtask

  op_t ops [9];

  initial begin
    ops[0] = '{32'h0000_2000, 32'd1,          4, 1'b0, 1'b0, 1'b0, 1'b0};
    ops[1] = '{32'h0000_2008, 32'h0000_0100,  4, 1'b0, 1'b0, 1'b0, 1'b0};
    ops[2] = '{32'h0000_2000, 32'h0000_1000,  4, 1'b1, 1'b0, 1'b0, 1'b0};
    ops[3] = '{32'h0000_2000, 32'h0000_2000,  1, 1'b1, 1'b0, 1'b0, 1'b1};
    ops[4] = '{32'h0000_1000, 32'h0000_3000,  4, 1'b0, 1'b0, 1'b0, 1'b0};
    ops[5] = '{32'h0000_3000, 32'h0000_4000,  4, 1'b0, 1'b1, 1'b0, 1'b0};
    ops[6] = '{32'h0000_4000, 32'h0000_5000,  4, 1'b0, 1'b0, 1'b1, 1'b0};
    ops[7] = '{32'h0000_4000, 32'hA5A5_0000,  4, 1'b1, 1'b0, 1'b0, 1'b0};
    ops[8] = '{32'hFFFF_FFF4, 32'h0000_6000,  4, 1'b0, 1'b0, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    #2;
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_res_ready", res_ready_o, 0);
    check("rst_awvalid", awvalid_o, 0);
    check("rst_wvalid", wvalid_o, 0);
    check("rst_wlast", wlast_o, 0);
    check("rst_bready", bready_o, 0);
    check("rst_awaddr", awaddr_o, 0);
    check("rst_wdata", wdata_o, 0);
    rst = 1'b0;

    for (int k = 0; k < 9; k++) run_op(ops[k]);

    repeat (4) @(negedge clk);
    #2;
    check("final_idle", busy_o, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mme_result_writer.md
MME_RESULT_WRITER -- requirements
Module: mme_result_writer

Interface
REQ-001 Parameter ADDR_W, default 32, AXI address width.
REQ-002 Parameter DATA_W, default 32, result and AXI data width; only 32 is supported.
REQ-003 Port clk, input, 1, single clock for all logic.
REQ-004 Port rst, input, 1, reset; synchronous and active-high.
REQ-005 Port start_i, input, 1, one-cycle start pulse.
REQ-006 Port c_addr_i, input, ADDR_W, base byte address of matrix C; sampled on an accepted start.
REQ-007 Port busy_o, output, 1, high from an accepted start until done.
REQ-008 Port done_o, output, 1, one-cycle completion pulse.
REQ-009 Port err_o, output, 1, sticky write-response error flag; cleared by the next accepted start.
REQ-010 Ports res_valid_i (input, 1), res_data_i (input, 32) and res_ready_o (output, 1) form the C-element stream from the MAC array, row-major, 16 elements.
REQ-011 Ports awaddr_o (ADDR_W), awlen_o (4), awsize_o (3), awburst_o (2), awvalid_o (1) are outputs and awready_i (1) is an input, forming the AXI write-address channel.
REQ-012 Ports wdata_o (32), wstrb_o (4), wlast_o (1), wvalid_o (1) are outputs and wready_i (1) is an input, forming the AXI write-data channel.
REQ-013 Ports bresp_i (2) and bvalid_i (1) are inputs and bready_o (1) is an output, forming the AXI write-response channel.

Function
REQ-014 The FSM SHALL have the states IDLE, FILL, AW, W, B and DONE.
REQ-015 IDLE: a start_i pulse latches c_addr_i with bits [3:0] forced to 0, clears the row counter and err_o, and moves to FILL; start_i SHALL be ignored in every other state.
REQ-016 FILL: res_ready_o=1; each res_valid_i&&res_ready_o handshake writes res_data_i into the 4-entry row buffer at the beat index; after the 4th handshake, move to AW.
REQ-017 res_ready_o SHALL be 0 in all states except FILL; the buffer is therefore never overrun.
REQ-018 AW: awvalid_o=1; awaddr_o=base+row*16; awlen_o=3; awsize_o=3'b010; awburst_o=INCR (2'b01); all of these SHALL be held stable until awready_i; on the handshake, move to W.
REQ-019 awvalid_o SHALL rise in the cycle after the 4th FILL handshake (1-cycle latency).
REQ-020 W: wvalid_o=1; wdata_o=buffer[beat]; wstrb_o=4'hF; wlast_o=1 only on beat 3; the beat counter advances only on wvalid_o&&wready_i; after the beat-3 handshake, move to B.
REQ-021 The W channel SHALL NOT be driven before the AW handshake of the same burst completes.
REQ-022 B: bready_o=1; on bvalid_i, if bresp_i is not 2'b00, set err_o.
REQ-023 After a B handshake: if row<3, increment row and return to FILL; if row==3, move to DONE.
REQ-024 DONE: done_o=1 for exactly one cycle, then move to IDLE; busy_o SHALL be 0 in IDLE and 1 in every other state.
REQ-025 An error SHALL NOT abort the operation: all 4 rows are still written, and err_o stays set through done_o.
REQ-026 Address arithmetic is ADDR_W-bit modular; row*16 on a 16-byte-aligned base never crosses a 4 KB boundary.
REQ-027 A start_i pulse in the DONE cycle SHALL be ignored; a start_i pulse in the first IDLE cycle after DONE SHALL be accepted.
REQ-028 Stalls: a low awready_i, wready_i or bvalid_i of any length SHALL hold state and outputs unchanged.

Reset
REQ-029 With rst=1 at a clk edge: state=IDLE; row and beat counters=0; busy_o, done_o, err_o, res_ready_o, awvalid_o, wvalid_o, wlast_o, bready_o=0; awaddr_o and wdata_o=0.
REQ-030 Reset asserted mid-operation (any state) SHALL abandon the transfer at the next edge with no further valid outputs; a new start is required afterwards.

Verification
REQ-031 Base 0x2000, results 1..16 streamed back-to-back, slave always ready -> 4 bursts at 0x2000/0x2010/0x2020/0x2030, data 1..16 in order, wlast on every 4th beat, one done_o pulse, err_o=0.
REQ-032 Base 0x2008 -> bursts issued at 0x2000..0x2030 (low 4 bits cleared).
REQ-033 Random awready_i/wready_i/bvalid_i stalls (0-5 cycles) and gaps in res_valid_i -> identical memory image, AXI signals stable while stalled, res_ready_o=0 outside FILL.
REQ-034 bresp_i=2'b10 on row 1 -> all 4 bursts still complete, err_o=1 at done_o; next start clears err_o.
REQ-035 rst pulse asserted during the W beat 2 of row 2 -> the next cycle shows busy_o=0 and all valids 0; a fresh start then writes all 16 words correctly.
REQ-036 start_i pulsed while busy and in the DONE cycle -> ignored, exactly 4 bursts and 1 done_o pulse.
